// File: rtl/buffer_arbiter_if.sv
// ============================================================================
// buffer_arbiter_if : request/grant/strobe bundle between the packet buffer
// arbiter, its requesters (AHB slave, USB RX/TX engines) and the buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface buffer_arbiter_if;
   logic       clear_req;
   logic [6:0] buffer_occupancy;

   logic       ahb_req;
   logic       ahb_write;
   logic [1:0] ahb_size;
   logic       ahb_ready;

   logic       rx_start;
   logic       rx_byte_valid;
   logic       rx_done;
   logic       tx_start;
   logic       tx_byte_req;
   logic       tx_done;

   logic       rx_grant;
   logic       tx_grant;

   logic       store_tx_data;
   logic       get_rx_data;
   logic       store_rx_packet_data;
   logic       get_tx_packet_data;
   logic       buffer_reserved;
   logic       buffer_clear;

   logic       overrun_err;
   logic       underrun_err;
   logic       timeout_err;

   // Requesters and buffer status side
   modport master (
      output clear_req, buffer_occupancy,
      output ahb_req, ahb_write, ahb_size,
      output rx_start, rx_byte_valid, rx_done,
      output tx_start, tx_byte_req, tx_done,
      input  ahb_ready, rx_grant, tx_grant,
      input  store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data,
      input  buffer_reserved, buffer_clear,
      input  overrun_err, underrun_err, timeout_err
   );

   // Arbiter side
   modport slave (
      input  clear_req, buffer_occupancy,
      input  ahb_req, ahb_write, ahb_size,
      input  rx_start, rx_byte_valid, rx_done,
      input  tx_start, tx_byte_req, tx_done,
      output ahb_ready, rx_grant, tx_grant,
      output store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data,
      output buffer_reserved, buffer_clear,
      output overrun_err, underrun_err, timeout_err
   );
endinterface

`default_nettype wire

// File: rtl/buffer_arbiter.sv
// ============================================================================
// buffer_arbiter : owns the 64-byte packet buffer, granting it per packet to
// USB RX/TX and per word to AHB, with occupancy and stall checking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module buffer_arbiter #(
   parameter int unsigned BUF_DEPTH      = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned CNT_W          = 10
) (
   input  wire logic        clk,
   input  wire logic        rst,
   buffer_arbiter_if.slave  arb_if
);

   localparam logic [7:0]       C_DEPTH8    = 8'(BUF_DEPTH);
   localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_ZERO  = '0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_AHB_XFER = 3'd1,
      S_RX_OWN   = 3'd2,
      S_TX_OWN   = 3'd3,
      S_FLUSH    = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;

   logic [7:0] w_wr_total;
   logic       w_wr_ok;
   logic       w_rd_ok;
   logic       w_ahb_accept;
   logic       w_not_full;
   logic       w_not_empty;
   logic       w_timeout_hit;

   logic w_ahb_ready;
   logic w_rx_grant;
   logic w_tx_grant;
   logic w_store_tx_data;
   logic w_get_rx_data;
   logic w_store_rx_packet_data;
   logic w_get_tx_packet_data;
   logic w_buffer_reserved;
   logic w_buffer_clear;
   logic w_overrun_err;
   logic w_underrun_err;
   logic w_timeout_err;

   // Occupancy checks, evaluated at 8 bits so a full buffer plus a 4-byte
   // write cannot wrap back into range.
   assign w_wr_total    = {1'b0, arb_if.buffer_occupancy} + {6'b0, arb_if.ahb_size} + 8'd1;
   assign w_wr_ok       = (w_wr_total <= C_DEPTH8);
   assign w_rd_ok       = (arb_if.buffer_occupancy >= 7'd4);
   assign w_ahb_accept  = arb_if.ahb_req && (arb_if.ahb_write ? w_wr_ok : w_rd_ok);
   assign w_not_full    = ({1'b0, arb_if.buffer_occupancy} < C_DEPTH8);
   assign w_not_empty   = (arb_if.buffer_occupancy != 7'd0);
   assign w_timeout_hit = (cnt_q == C_TIMEOUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= C_CNT_ZERO;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
      end
   end

   always_comb begin
      state_d                = state_q;
      cnt_d                  = cnt_q;
      write_d                = write_q;
      w_ahb_ready            = 1'b0;
      w_rx_grant             = 1'b0;
      w_tx_grant             = 1'b0;
      w_store_tx_data        = 1'b0;
      w_get_rx_data          = 1'b0;
      w_store_rx_packet_data = 1'b0;
      w_get_tx_packet_data   = 1'b0;
      w_buffer_reserved      = 1'b0;
      w_buffer_clear         = 1'b0;
      w_overrun_err          = 1'b0;
      w_underrun_err         = 1'b0;
      w_timeout_err          = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Counter is held at zero here so every packet starts fresh.
            cnt_d = C_CNT_ZERO;
            if (arb_if.clear_req) begin
               state_d = S_FLUSH;
            end else if (arb_if.rx_start) begin
               state_d = S_RX_OWN;
            end else if (w_ahb_accept) begin
               state_d = S_AHB_XFER;
               write_d = arb_if.ahb_write;
            end else if (arb_if.tx_start) begin
               state_d = S_TX_OWN;
            end
         end

         S_AHB_XFER: begin
            w_ahb_ready = 1'b1;
            if (arb_if.clear_req) begin
               state_d = S_FLUSH;
            end else begin
               w_store_tx_data = write_q;
               w_get_rx_data   = !write_q;
               state_d         = S_IDLE;
            end
         end

         S_RX_OWN: begin
            w_rx_grant             = 1'b1;
            w_buffer_reserved      = 1'b1;
            w_store_rx_packet_data = arb_if.rx_byte_valid && w_not_full;
            w_overrun_err          = arb_if.rx_byte_valid && !w_not_full;
            cnt_d = arb_if.rx_byte_valid ? C_CNT_ZERO : cnt_q + C_CNT_ONE;
            if (arb_if.clear_req) begin
               state_d = S_FLUSH;
            end else if (arb_if.rx_done) begin
               state_d = S_IDLE;
            end else if (w_timeout_hit) begin
               w_timeout_err = 1'b1;
               state_d       = S_FLUSH;
            end
         end

         S_TX_OWN: begin
            w_tx_grant           = 1'b1;
            w_buffer_reserved    = 1'b1;
            w_get_tx_packet_data = arb_if.tx_byte_req && w_not_empty;
            w_underrun_err       = arb_if.tx_byte_req && !w_not_empty;
            cnt_d = arb_if.tx_byte_req ? C_CNT_ZERO : cnt_q + C_CNT_ONE;
            if (arb_if.clear_req) begin
               state_d = S_FLUSH;
            end else if (arb_if.tx_done) begin
               state_d = S_IDLE;
            end else if (w_timeout_hit) begin
               w_timeout_err = 1'b1;
               state_d       = S_FLUSH;
            end
         end

         S_FLUSH: begin
            w_buffer_clear = 1'b1;
            state_d        = arb_if.clear_req ? S_FLUSH : S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign arb_if.ahb_ready            = w_ahb_ready;
   assign arb_if.rx_grant             = w_rx_grant;
   assign arb_if.tx_grant             = w_tx_grant;
   assign arb_if.store_tx_data        = w_store_tx_data;
   assign arb_if.get_rx_data          = w_get_rx_data;
   assign arb_if.store_rx_packet_data = w_store_rx_packet_data;
   assign arb_if.get_tx_packet_data   = w_get_tx_packet_data;
   assign arb_if.buffer_reserved      = w_buffer_reserved;
   assign arb_if.buffer_clear         = w_buffer_clear;
   assign arb_if.overrun_err          = w_overrun_err;
   assign arb_if.underrun_err         = w_underrun_err;
   assign arb_if.timeout_err          = w_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
// ============================================================================
// tb_buffer_arbiter : directed self-checking bench for buffer_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_buffer_arbiter;

   localparam logic [11:0] M_READY = 12'h800;
   localparam logic [11:0] M_RXG   = 12'h400;
   localparam logic [11:0] M_TXG   = 12'h200;
   localparam logic [11:0] M_STTX  = 12'h100;
   localparam logic [11:0] M_GETRX = 12'h080;
   localparam logic [11:0] M_STRX  = 12'h040;
   localparam logic [11:0] M_GETTX = 12'h020;
   localparam logic [11:0] M_RESV  = 12'h010;
   localparam logic [11:0] M_CLR   = 12'h008;
   localparam logic [11:0] M_OVR   = 12'h004;
   localparam logic [11:0] M_UND   = 12'h002;
   localparam logic [11:0] M_TMO   = 12'h001;
   localparam logic [11:0] M_NONE  = 12'h000;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   buffer_arbiter_if bus ();

   buffer_arbiter #(
      .BUF_DEPTH      (64),
      .TIMEOUT_CYCLES (1023),
      .CNT_W          (10)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] outs();
      return {bus.ahb_ready, bus.rx_grant, bus.tx_grant, bus.store_tx_data,
              bus.get_rx_data, bus.store_rx_packet_data, bus.get_tx_packet_data,
              bus.buffer_reserved, bus.buffer_clear, bus.overrun_err,
              bus.underrun_err, bus.timeout_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      bus.clear_req        = 1'b0;
      bus.buffer_occupancy = 7'd0;
      bus.ahb_req          = 1'b0;
      bus.ahb_write        = 1'b0;
      bus.ahb_size         = 2'd0;
      bus.rx_start         = 1'b0;
      bus.rx_byte_valid    = 1'b0;
      bus.rx_done          = 1'b0;
      bus.tx_start         = 1'b0;
      bus.tx_byte_req      = 1'b0;
      bus.tx_done          = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      settle();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", outs(), M_NONE);
      end
   endtask

   task automatic test_ahb_write();
      bus.ahb_req = 1'b1; bus.ahb_write = 1'b1; bus.ahb_size = 2'd3;
      bus.buffer_occupancy = 7'd0;
      settle();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL ahb_wr_idle: got %h expected %h", outs(), M_NONE);
      end
      tick();
      checks++;
      if (outs() !== (M_READY | M_STTX)) begin
         errors++;
         $display("FAIL ahb_wr_xfer: got %h expected %h", outs(), M_READY | M_STTX);
      end
      bus.ahb_req = 1'b0;
      tick();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL ahb_wr_back_idle: got %h expected %h", outs(), M_NONE);
      end
   endtask

   task automatic test_ahb_backpressure();
      int readies;
      readies = 0;
      bus.ahb_req = 1'b1; bus.ahb_write = 1'b1; bus.ahb_size = 2'd3;
      bus.buffer_occupancy = 7'd62;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (bus.ahb_ready) readies++;
         tick();
      end
      checks++;
      if (readies !== 0) begin
         errors++;
         $display("FAIL ahb_wr_reject: ready pulses %0d expected 0", readies);
      end
      bus.buffer_occupancy = 7'd60;
      tick();
      checks++;
      if (outs() !== (M_READY | M_STTX)) begin
         errors++;
         $display("FAIL ahb_wr_exact_fit: got %h expected %h", outs(), M_READY | M_STTX);
      end
      bus.ahb_req = 1'b0;
      tick();

      // Read needs at least four bytes present
      bus.ahb_req = 1'b1; bus.ahb_write = 1'b0; bus.buffer_occupancy = 7'd3;
      tick();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL ahb_rd_reject: got %h expected %h", outs(), M_NONE);
      end
      bus.buffer_occupancy = 7'd4;
      tick();
      checks++;
      if (outs() !== (M_READY | M_GETRX)) begin
         errors++;
         $display("FAIL ahb_rd_accept: got %h expected %h", outs(), M_READY | M_GETRX);
      end
      bus.ahb_req = 1'b0;
      tick();

      // Rejected write does not block a TX grant in the same cycle
      bus.ahb_req = 1'b1; bus.ahb_write = 1'b1; bus.ahb_size = 2'd3;
      bus.buffer_occupancy = 7'd62; bus.tx_start = 1'b1;
      tick();
      bus.tx_start = 1'b0;
      settle();
      checks++;
      if (outs() !== (M_TXG | M_RESV)) begin
         errors++;
         $display("FAIL tx_over_rejected_ahb: got %h expected %h", outs(), M_TXG | M_RESV);
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      bus.ahb_req = 1'b0;
      settle();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL tx_done_idle: got %h expected %h", outs(), M_NONE);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_rx_priority();
      int stores;
      stores = 0;
      bus.rx_start = 1'b1;
      bus.ahb_req = 1'b1; bus.ahb_write = 1'b1; bus.ahb_size = 2'd0;
      bus.buffer_occupancy = 7'd10;
      tick();
      bus.rx_start = 1'b0;
      settle();
      checks++;
      if (outs() !== (M_RXG | M_RESV)) begin
         errors++;
         $display("FAIL rx_over_ahb: got %h expected %h", outs(), M_RXG | M_RESV);
      end
      for (int i = 0; i < 5; i++) begin
         bus.rx_byte_valid = 1'b1;
         settle();
         if (bus.store_rx_packet_data) stores++;
         tick();
      end
      checks++;
      if (stores !== 5) begin
         errors++;
         $display("FAIL rx_stream_count: stores %0d expected 5", stores);
      end
      // Full buffer: byte dropped with overrun
      bus.buffer_occupancy = 7'd64;
      settle();
      checks++;
      if (outs() !== (M_RXG | M_RESV | M_OVR)) begin
         errors++;
         $display("FAIL rx_overrun: got %h expected %h", outs(), M_RXG | M_RESV | M_OVR);
      end
      tick();
      // Byte on the done cycle still stored
      bus.buffer_occupancy = 7'd63;
      bus.rx_done = 1'b1;
      settle();
      checks++;
      if (outs() !== (M_RXG | M_RESV | M_STRX)) begin
         errors++;
         $display("FAIL rx_done_byte: got %h expected %h", outs(), M_RXG | M_RESV | M_STRX);
      end
      tick();
      bus.rx_done = 1'b0; bus.rx_byte_valid = 1'b0;
      bus.buffer_occupancy = 7'd10;
      settle();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL rx_back_idle: got %h expected %h", outs(), M_NONE);
      end
      tick();
      checks++;
      if (outs() !== (M_READY | M_STTX)) begin
         errors++;
         $display("FAIL ahb_after_rx: got %h expected %h", outs(), M_READY | M_STTX);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_tx_underrun();
      int gets;
      gets = 0;
      bus.tx_start = 1'b1; bus.buffer_occupancy = 7'd0;
      tick();
      bus.tx_start = 1'b0;
      bus.tx_byte_req = 1'b1;
      settle();
      checks++;
      if (outs() !== (M_TXG | M_RESV | M_UND)) begin
         errors++;
         $display("FAIL tx_underrun: got %h expected %h", outs(), M_TXG | M_RESV | M_UND);
      end
      tick();
      bus.buffer_occupancy = 7'd3;
      for (int i = 0; i < 3; i++) begin
         settle();
         if (bus.get_tx_packet_data && !bus.underrun_err) gets++;
         tick();
         bus.buffer_occupancy = bus.buffer_occupancy - 7'd1;
      end
      checks++;
      if (gets !== 3) begin
         errors++;
         $display("FAIL tx_get_count: gets %0d expected 3", gets);
      end
      bus.buffer_occupancy = 7'd2;
      bus.tx_done = 1'b1;
      settle();
      checks++;
      if (outs() !== (M_TXG | M_RESV | M_GETTX)) begin
         errors++;
         $display("FAIL tx_done_byte: got %h expected %h", outs(), M_TXG | M_RESV | M_GETTX);
      end
      tick();
      bus.tx_done = 1'b0; bus.tx_byte_req = 1'b0;
      settle();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL tx_back_idle: got %h expected %h", outs(), M_NONE);
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      int  k;
      bit  seen;
      seen = 1'b0;
      k    = 0;
      bus.rx_start = 1'b1;
      tick();
      bus.rx_start = 1'b0;
      // Cycle index k counts RX_OWN cycles from entry (entry cycle is 0)
      while (k < 1100 && !seen) begin
         settle();
         if (bus.timeout_err) begin
            seen = 1'b1;
         end else begin
            tick();
            k++;
         end
      end
      checks++;
      if (!seen || k !== 1023) begin
         errors++;
         $display("FAIL timeout_cycle: seen %0d at cycle %0d expected cycle 1023", seen, k);
      end
      checks++;
      if (outs() !== (M_RXG | M_RESV | M_TMO)) begin
         errors++;
         $display("FAIL timeout_outputs: got %h expected %h", outs(), M_RXG | M_RESV | M_TMO);
      end
      tick();
      checks++;
      if (outs() !== M_CLR) begin
         errors++;
         $display("FAIL timeout_flush: got %h expected %h", outs(), M_CLR);
      end
      tick();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL timeout_back_idle: got %h expected %h", outs(), M_NONE);
      end
   endtask

   task automatic test_clear();
      bus.ahb_req = 1'b1; bus.ahb_write = 1'b1; bus.ahb_size = 2'd0;
      bus.buffer_occupancy = 7'd0;
      tick();
      bus.clear_req = 1'b1;
      settle();
      checks++;
      if (outs() !== M_READY) begin
         errors++;
         $display("FAIL clear_in_xfer: got %h expected %h", outs(), M_READY);
      end
      bus.ahb_req = 1'b0;
      tick();
      bus.clear_req = 1'b0;
      settle();
      checks++;
      if (outs() !== M_CLR) begin
         errors++;
         $display("FAIL clear_flush: got %h expected %h", outs(), M_CLR);
      end
      tick();
      // clear_req beats rx_done while RX owns the buffer
      bus.rx_start = 1'b1;
      tick();
      bus.rx_start = 1'b0;
      bus.rx_done = 1'b1; bus.clear_req = 1'b1;
      tick();
      bus.rx_done = 1'b0; bus.clear_req = 1'b0;
      settle();
      checks++;
      if (outs() !== M_CLR) begin
         errors++;
         $display("FAIL clear_over_done: got %h expected %h", outs(), M_CLR);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_rst_tx();
      bus.tx_start = 1'b1; bus.buffer_occupancy = 7'd5;
      tick();
      bus.tx_start = 1'b0;
      settle();
      checks++;
      if (outs() !== (M_TXG | M_RESV)) begin
         errors++;
         $display("FAIL rst_tx_owned: got %h expected %h", outs(), M_TXG | M_RESV);
      end
      rst = 1'b1;
      bus.tx_byte_req = 1'b1;
      tick();
      settle();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL rst_tx_cleared: got %h expected %h", outs(), M_NONE);
      end
      rst = 1'b0;
      idle_inputs();
      tick();
      checks++;
      if (outs() !== M_NONE) begin
         errors++;
         $display("FAIL rst_tx_no_flush: got %h expected %h", outs(), M_NONE);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_ahb_write();
      test_ahb_backpressure();
      test_rx_priority();
      test_tx_underrun();
      test_timeout();
      test_clear();
      test_rst_tx();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/buffer_arbiter.md
Name: buffer_arbiter

Overview:
- Owns access to the 64-byte packet data buffer and shares it between the AHB-Lite slave (word reads/writes) and the USB RX/TX packet engines (byte streams).
- Grants exclusive ownership for a whole packet, sequences single AHB transfers between packets, and generates the store/get/reserved/clear strobes into the buffer.
- Checks occupancy on every request and flags overrun, underrun and stalled-packet timeout.

Parameters:
- BUF_DEPTH, 64, buffer capacity in bytes.
- TIMEOUT_CYCLES, 1023, idle cycles allowed inside a packet before ownership is revoked.
- CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear_req  in  1  flush request from the protocol controller.
- buffer_occupancy  in  7  current byte count from the buffer.
- ahb_req  in  1  AHB slave requests one transfer; held until ahb_ready.
- ahb_write  in  1  1 = store TX data, 0 = fetch RX data; valid with ahb_req.
- ahb_size  in  2  bytes-1 for a write; valid with ahb_req.
- ahb_ready  out  1  one-cycle pulse: transfer performed this cycle.
- rx_start  in  1  RX requests the buffer for an incoming packet.
- rx_byte_valid  in  1  RX byte available this cycle.
- rx_done  in  1  RX packet end.
- tx_start  in  1  TX requests the buffer for an outgoing packet.
- tx_byte_req  in  1  TX wants one byte this cycle.
- tx_done  in  1  TX packet end.
- rx_grant  out  1  RX owns the buffer.
- tx_grant  out  1  TX owns the buffer.
- store_tx_data  out  1  to buffer: AHB write strobe.
- get_rx_data  out  1  to buffer: AHB read strobe.
- store_rx_packet_data  out  1  to buffer: RX byte write strobe.
- get_tx_packet_data  out  1  to buffer: TX byte read strobe.
- buffer_reserved  out  1  to buffer: USB side owns the buffer.
- buffer_clear  out  1  to buffer: flush.
- overrun_err  out  1  one-cycle pulse.
- underrun_err  out  1  one-cycle pulse.
- timeout_err  out  1  one-cycle pulse.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: state IDLE, timeout counter 0, every output 0.
- State IDLE. Priority order is clear_req > rx_start > ahb_req (only if accepted) > tx_start.
  - clear_req → FLUSH.
  - rx_start → RX_OWN.
  - Accepted ahb_req → AHB_XFER.
  - tx_start → TX_OWN.
  - AHB write is accepted iff buffer_occupancy + ahb_size + 1 <= BUF_DEPTH, computed at 8 bits. AHB read is accepted iff buffer_occupancy >= 4.
  - A rejected ahb_req stays pending with no strobe and no error; tx_start may be granted that cycle.
- State AHB_XFER: lasts exactly 1 cycle.
  - ahb_ready = 1.
  - store_tx_data = ahb_write, get_rx_data = !ahb_write.
  - Next state is IDLE, giving a 2-cycle minimum per AHB transfer.
  - If clear_req is high this cycle, the strobes are suppressed, ahb_ready still pulses, and the next state is FLUSH.
- State RX_OWN:
  - rx_grant = 1, buffer_reserved = 1.
  - store_rx_packet_data = rx_byte_valid && buffer_occupancy < BUF_DEPTH (combinational).
  - rx_byte_valid while full → overrun_err pulse; byte dropped; state kept.
  - rx_done → IDLE next cycle. A byte presented in the same cycle is still stored.
- State TX_OWN:
  - tx_grant = 1, buffer_reserved = 1.
  - get_tx_packet_data = tx_byte_req && buffer_occupancy != 0.
  - tx_byte_req while empty → underrun_err pulse.
  - tx_done → IDLE. A same-cycle byte request is still served.
- Timeout (RX_OWN and TX_OWN only):
  - The counter clears on entry and on any rx_byte_valid/tx_byte_req; otherwise it increments.
  - When the counter reaches TIMEOUT_CYCLES: timeout_err pulse, grant dropped, next state FLUSH.
  - A done signal in the same cycle wins: go to IDLE, no error.
- State FLUSH: lasts 1 cycle.
  - buffer_clear = 1, all other strobes and grants 0.
  - Next state IDLE.
- clear_req in any state → FLUSH next cycle. It has priority over done, start and timeout. Grants drop in the cycle FLUSH is entered.
- rst mid-packet: next cycle is IDLE with all outputs 0. No buffer_clear is issued; the buffer's own reset covers it.
- Strobes are mutually exclusive by construction. Errors never change the pending AHB request.

Test Plan:
- rst, then AHB write, size=3, occupancy=0 → AHB_XFER next cycle; store_tx_data=1 and ahb_ready=1 for exactly 1 cycle; back in IDLE.
- Occupancy=62, AHB write size=3 → no ahb_ready for 10 cycles. Drop occupancy to 60 → accepted on the following cycle.
- rx_start and ahb_req same cycle → rx_grant=1, buffer_reserved=1. Stream 5 rx_byte_valid → 5 store_rx_packet_data pulses; rx_done → IDLE. AHB served on the next cycle.
- TX_OWN, occupancy=0, tx_byte_req → underrun_err pulse and no get_tx_packet_data. Occupancy=3 → 3 get strobes for 3 requests.
- RX_OWN with no bytes for 1023 cycles → timeout_err in that cycle, FLUSH with buffer_clear=1 for 1 cycle, then IDLE.
- clear_req during AHB_XFER → no store strobe; buffer_clear on the next cycle. rst during TX_OWN → all outputs 0 after the edge.
